// File: rtl/load_store_unit_pkg.sv
// Shared encodings for the load/store unit: funct3 values, bus size codes,
// exception causes and FSM states.
package load_store_unit_pkg;

   // funct3 encodings; stores share the low three with loads
   localparam logic [2:0] F3Byte  = 3'b000;
   localparam logic [2:0] F3Half  = 3'b001;
   localparam logic [2:0] F3Word  = 3'b010;
   localparam logic [2:0] F3ByteU = 3'b100;
   localparam logic [2:0] F3HalfU = 3'b101;

   // Bus controller size codes, equal to funct3[1:0]
   localparam logic [1:0] SizeByte = 2'b00;
   localparam logic [1:0] SizeHalf = 2'b01;
   localparam logic [1:0] SizeWord = 2'b10;

   typedef enum logic [1:0] {
      CauseNone       = 2'b00,
      CauseMisaligned = 2'b01,
      CauseIllegal    = 2'b10,
      CauseTimeout    = 2'b11
   } lsu_cause_e;

   typedef enum logic [1:0] {
      StIdle   = 2'b00,
      StAccess = 2'b01,
      StResp   = 2'b10
   } lsu_state_e;

endpackage

// File: rtl/load_store_unit_if.sv
// Request, response and data-bus signals of the load/store unit.
// slave is the unit's view; master is the core plus bus controller side.
interface load_store_unit_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_store;
   logic [2:0]  req_funct3;
   logic [31:0] req_base;
   logic [11:0] req_imm;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic [1:0]  resp_cause;
   logic [31:0] resp_addr;
   logic        bus_wd;
   logic        bus_rd;
   logic [1:0]  bus_size;
   logic [31:0] bus_addr;
   logic [31:0] bus_wdata;
   logic [31:0] bus_rdata;
   logic        bus_ready;
   logic        bus_busy;

   modport slave (
      input  req_valid, req_store, req_funct3, req_base, req_imm, req_wdata,
      input  bus_rdata, bus_ready, bus_busy,
      output req_ready, resp_valid, resp_rdata, resp_cause, resp_addr,
      output bus_wd, bus_rd, bus_size, bus_addr, bus_wdata
   );

   modport master (
      output req_valid, req_store, req_funct3, req_base, req_imm, req_wdata,
      output bus_rdata, bus_ready, bus_busy,
      input  req_ready, resp_valid, resp_rdata, resp_cause, resp_addr,
      input  bus_wd, bus_rd, bus_size, bus_addr, bus_wdata
   );
endinterface

// File: rtl/lsu_align_ext.sv
// Combinational request legality/alignment check and load-data extension.
module lsu_align_ext
   import load_store_unit_pkg::*;
(
   input  logic        chk_store,
   input  logic [2:0]  chk_funct3,
   input  logic [1:0]  chk_ea,
   input  logic [2:0]  ext_funct3,
   input  logic [31:0] ext_rdata,
   output logic        misaligned,
   output logic        illegal,
   output logic [31:0] ext_data
);

   always_comb begin
      if (chk_store) begin
         illegal = !(chk_funct3 inside {F3Byte, F3Half, F3Word});
      end else begin
         illegal = !(chk_funct3 inside {F3Byte, F3Half, F3Word, F3ByteU, F3HalfU});
      end
   end

   always_comb begin
      case (chk_funct3[1:0])
         SizeByte: misaligned = 1'b0;
         SizeHalf: misaligned = chk_ea[0];
         SizeWord: misaligned = |chk_ea;
         default:  misaligned = 1'b0;
      endcase
   end

   always_comb begin
      case (ext_funct3)
         F3Byte:  ext_data = {{24{ext_rdata[7]}}, ext_rdata[7:0]};
         F3Half:  ext_data = {{16{ext_rdata[15]}}, ext_rdata[15:0]};
         F3ByteU: ext_data = {24'h0, ext_rdata[7:0]};
         F3HalfU: ext_data = {16'h0, ext_rdata[15:0]};
         default: ext_data = ext_rdata;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: accepts one request per handshake, drives a single
// bus strobe, and answers with a one-cycle response pulse.
module load_store_unit
   import load_store_unit_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input logic              clk,
   input logic              rst,
   load_store_unit_if.slave lsu_bus
);

   localparam logic [7:0] CntLast = 8'(TIMEOUT_CYCLES - 1);

   lsu_state_e  state_q;
   lsu_cause_e  cause_q;
   logic [31:0] ea_q, wdata_q, rdata_q, resp_addr_q;
   logic [2:0]  funct3_q;
   logic [7:0]  cnt_q;
   logic        store_q, wd_q, rd_q, rv_q;

   logic [31:0] ea, ext_data;
   logic        misaligned, illegal, go;

   assign ea = lsu_bus.req_base + {{20{lsu_bus.req_imm[11]}}, lsu_bus.req_imm};
   assign go = lsu_bus.bus_ready && !lsu_bus.bus_busy;

   lsu_align_ext u_align_ext (
      .chk_store  (lsu_bus.req_store),
      .chk_funct3 (lsu_bus.req_funct3),
      .chk_ea     (ea[1:0]),
      .ext_funct3 (funct3_q),
      .ext_rdata  (lsu_bus.bus_rdata),
      .misaligned (misaligned),
      .illegal    (illegal),
      .ext_data   (ext_data)
   );

   // Strobes are set at the edge that leaves the unit in ACCESS, so each lasts
   // exactly one ACCESS cycle; response fields are cleared outside RESP.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= StIdle;
         cause_q     <= CauseNone;
         ea_q        <= '0;
         wdata_q     <= '0;
         rdata_q     <= '0;
         resp_addr_q <= '0;
         funct3_q    <= '0;
         cnt_q       <= '0;
         store_q     <= 1'b0;
         wd_q        <= 1'b0;
         rd_q        <= 1'b0;
         rv_q        <= 1'b0;
      end else begin
         wd_q        <= 1'b0;
         rd_q        <= 1'b0;
         rv_q        <= 1'b0;
         rdata_q     <= '0;
         cause_q     <= CauseNone;
         resp_addr_q <= '0;
         unique case (state_q)
            StIdle: begin
               if (lsu_bus.req_valid) begin
                  ea_q     <= ea;
                  funct3_q <= lsu_bus.req_funct3;
                  store_q  <= lsu_bus.req_store;
                  wdata_q  <= lsu_bus.req_wdata;
                  if (illegal || misaligned) begin
                     rv_q        <= 1'b1;
                     cause_q     <= illegal ? CauseIllegal : CauseMisaligned;
                     resp_addr_q <= ea;
                     state_q     <= StResp;
                  end else begin
                     cnt_q   <= '0;
                     wd_q    <= go && lsu_bus.req_store;
                     rd_q    <= go && !lsu_bus.req_store;
                     state_q <= StAccess;
                  end
               end
            end
            StAccess: begin
               if (wd_q || rd_q) begin
                  rv_q        <= 1'b1;
                  rdata_q     <= store_q ? '0 : ext_data;
                  resp_addr_q <= ea_q;
                  state_q     <= StResp;
               end else if (cnt_q == CntLast) begin
                  rv_q        <= 1'b1;
                  cause_q     <= CauseTimeout;
                  resp_addr_q <= ea_q;
                  state_q     <= StResp;
               end else begin
                  cnt_q <= cnt_q + 8'd1;
                  wd_q  <= go && store_q;
                  rd_q  <= go && !store_q;
               end
            end
            StResp:  state_q <= StIdle;
            default: state_q <= StIdle;
         endcase
      end
   end

   assign lsu_bus.req_ready  = (state_q == StIdle);
   assign lsu_bus.resp_valid = rv_q;
   assign lsu_bus.resp_rdata = rdata_q;
   assign lsu_bus.resp_cause = cause_q;
   assign lsu_bus.resp_addr  = resp_addr_q;
   assign lsu_bus.bus_wd     = wd_q;
   assign lsu_bus.bus_rd     = rd_q;
   assign lsu_bus.bus_size   = funct3_q[1:0];
   assign lsu_bus.bus_addr   = ea_q;
   assign lsu_bus.bus_wdata  = wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a transaction-level model fills per-cycle
// expectation tables that a negedge process compares against the DUT.
module tb_load_store_unit;
   localparam int unsigned T = 16;
   localparam int MaxCyc = 2048;

   bit clk = 1'b0;
   logic rst = 1'b0;
   logic mem_clr = 1'b1;
   int cyc = 0;
   int n_cmp = 0;
   int n_fail = 0;

   load_store_unit_if lsu_bus ();

   load_store_unit #(.TIMEOUT_CYCLES(T)) dut (
      .clk     (clk),
      .rst     (rst),
      .lsu_bus (lsu_bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Bus controller model: byte memory, right-justified read data.
   logic [7:0]  bmem [4096];
   logic [7:0]  rmem [4096];
   logic [11:0] ba;
   assign ba = lsu_bus.bus_addr[11:0];
   assign lsu_bus.bus_rdata = lsu_bus.bus_rd ?
      {bmem[ba + 12'd3], bmem[ba + 12'd2], bmem[ba + 12'd1], bmem[ba]} : 32'hA5A5_A5A5;

   function automatic int nbytes(input logic [1:0] s);
      return (s == 2'b00) ? 1 : ((s == 2'b01) ? 2 : 4);
   endfunction

   always @(posedge clk) begin
      if (mem_clr) begin
         for (int i = 0; i < 4096; i++) bmem[i] <= 8'h00;
      end else if (lsu_bus.bus_wd) begin
         for (int i = 0; i < nbytes(lsu_bus.bus_size); i++)
            bmem[ba + 12'(i)] <= lsu_bus.bus_wdata[8*i +: 8];
      end
   end

   // Expectation tables indexed by cycle (cycle n follows rising edge n)
   bit          e_ready [MaxCyc];
   bit          e_rv    [MaxCyc];
   bit          e_wd    [MaxCyc];
   bit          e_rd    [MaxCyc];
   logic [31:0] e_rdata [MaxCyc];
   logic [31:0] e_addr  [MaxCyc];
   logic [1:0]  e_cause [MaxCyc];
   logic [31:0] e_baddr [MaxCyc];
   logic [31:0] e_bwdata[MaxCyc];
   logic [1:0]  e_size  [MaxCyc];

   function automatic logic f3_illegal(input logic st, input logic [2:0] f);
      if (st) return !(f == 3'd0 || f == 3'd1 || f == 3'd2);
      return !(f == 3'd0 || f == 3'd1 || f == 3'd2 || f == 3'd4 || f == 3'd5);
   endfunction

   function automatic logic f3_misaligned(input logic [2:0] f, input logic [31:0] ea);
      if (f[1:0] == 2'b01) return ea[0];
      if (f[1:0] == 2'b10) return ea[1:0] != 2'b00;
      return 1'b0;
   endfunction

   function automatic logic [31:0] load_val(input logic [2:0] f, input logic [31:0] w);
      case (f)
         3'd0:    return 32'($signed(w[7:0]));
         3'd1:    return 32'($signed(w[15:0]));
         3'd2:    return w;
         3'd4:    return 32'(w[7:0]);
         3'd5:    return 32'(w[15:0]);
         default: return 32'h0;
      endcase
   endfunction

   function automatic logic [31:0] ref_word(input logic [11:0] a);
      return {rmem[a + 12'd3], rmem[a + 12'd2], rmem[a + 12'd1], rmem[a]};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got 0x%08h, expected 0x%08h", name, cyc, act, exp);
      end
   endtask

   logic [31:0] last_rdata, last_addr, last_saddr;
   logic [1:0]  last_cause, last_ssize;
   int          last_rv_cyc = 0;
   int          n_resp = 0;
   int          n_strobe = 0;

   always @(negedge clk) begin
      if (cyc >= 1 && cyc < MaxCyc) begin
         chk("req_ready", 32'(lsu_bus.req_ready), 32'(e_ready[cyc]));
         chk("bus_wd", 32'(lsu_bus.bus_wd), 32'(e_wd[cyc]));
         chk("bus_rd", 32'(lsu_bus.bus_rd), 32'(e_rd[cyc]));
         chk("resp_valid", 32'(lsu_bus.resp_valid), 32'(e_rv[cyc]));
         if (e_rv[cyc]) begin
            chk("resp_rdata", lsu_bus.resp_rdata, e_rdata[cyc]);
            chk("resp_cause", 32'(lsu_bus.resp_cause), 32'(e_cause[cyc]));
            chk("resp_addr", lsu_bus.resp_addr, e_addr[cyc]);
         end else if (e_ready[cyc]) begin
            chk("idle_resp_rdata", lsu_bus.resp_rdata, 32'h0);
            chk("idle_resp_cause", 32'(lsu_bus.resp_cause), 32'h0);
            chk("idle_resp_addr", lsu_bus.resp_addr, 32'h0);
         end
         if (e_wd[cyc] || e_rd[cyc]) begin
            chk("bus_addr", lsu_bus.bus_addr, e_baddr[cyc]);
            chk("bus_size", 32'(lsu_bus.bus_size), 32'(e_size[cyc]));
            if (e_wd[cyc]) chk("bus_wdata", lsu_bus.bus_wdata, e_bwdata[cyc]);
         end
      end
      if (lsu_bus.resp_valid === 1'b1) begin
         last_rdata  <= lsu_bus.resp_rdata;
         last_cause  <= lsu_bus.resp_cause;
         last_addr   <= lsu_bus.resp_addr;
         last_rv_cyc <= cyc;
         n_resp      <= n_resp + 1;
      end
      if (lsu_bus.bus_wd === 1'b1 || lsu_bus.bus_rd === 1'b1) begin
         last_saddr <= lsu_bus.bus_addr;
         last_ssize <= lsu_bus.bus_size;
         n_strobe   <= n_strobe + 1;
      end
   end

   task automatic drive_bus(input logic good, input logic use_busy);
      if (good) begin
         lsu_bus.bus_ready = 1'b1; lsu_bus.bus_busy = 1'b0;
      end else if (use_busy) begin
         lsu_bus.bus_ready = 1'b1; lsu_bus.bus_busy = 1'b1;
      end else begin
         lsu_bus.bus_ready = 1'b0; lsu_bus.bus_busy = 1'b0;
      end
   endtask

   // Issues one request; the bus stays unready for 'stall' cycles after issue.
   // rst_after >= 0 pulses reset during that ACCESS cycle instead of completing.
   task automatic do_req(input logic st, input logic [2:0] f3, input logic [31:0] base,
                         input logic [11:0] imm, input logic [31:0] wd, input int stall,
                         input logic use_busy, input int rst_after, output int acc);
      logic [31:0] ea;
      logic [1:0]  cause;
      int          strobe_c, resp_c, last_c;
      ea = base + {{20{imm[11]}}, imm};
      acc = cyc + 1;
      cause = f3_illegal(st, f3) ? 2'b10 : (f3_misaligned(f3, ea) ? 2'b01 : 2'b00);
      strobe_c = -1;
      if (cause != 2'b00) begin
         resp_c = acc;
      end else if (stall >= int'(T)) begin
         cause  = 2'b11;
         resp_c = acc + int'(T);
      end else begin
         strobe_c = acc + stall;
         resp_c   = strobe_c + 1;
      end
      if (rst_after >= 0) begin
         resp_c = -1;
         last_c = acc + rst_after;
      end else begin
         last_c = resp_c;
      end
      for (int c = acc; c <= last_c; c++) e_ready[c] = 1'b0;
      if (resp_c >= 0) begin
         e_rv[resp_c]    = 1'b1;
         e_cause[resp_c] = cause;
         e_addr[resp_c]  = ea;
         e_rdata[resp_c] = (cause == 2'b00 && !st) ? load_val(f3, ref_word(ea[11:0])) : 32'h0;
      end
      if (strobe_c >= 0 && rst_after < 0) begin
         if (st) e_wd[strobe_c] = 1'b1;
         else    e_rd[strobe_c] = 1'b1;
         e_baddr[strobe_c]  = ea;
         e_size[strobe_c]   = f3[1:0];
         e_bwdata[strobe_c] = wd;
         if (st) for (int i = 0; i < nbytes(f3[1:0]); i++) rmem[ea[11:0] + 12'(i)] = wd[8*i +: 8];
      end
      lsu_bus.req_valid  = 1'b1;
      lsu_bus.req_store  = st;
      lsu_bus.req_funct3 = f3;
      lsu_bus.req_base   = base;
      lsu_bus.req_imm    = imm;
      lsu_bus.req_wdata  = wd;
      drive_bus(strobe_c >= 0 && cyc >= strobe_c - 1, use_busy);
      @(posedge clk); #1;
      lsu_bus.req_valid = 1'b0;
      while (cyc <= last_c) begin
         if (rst_after >= 0 && cyc == last_c) rst = 1'b0;
         drive_bus(strobe_c >= 0 && cyc >= strobe_c - 1, use_busy);
         @(posedge clk); #1;
      end
      rst = 1'b1;
      drive_bus(1'b0, 1'b0);
   endtask

   int a, a2, s0, r0;

   initial begin
      for (int i = 0; i < MaxCyc; i++) begin
         e_ready[i] = 1'b1; e_rv[i] = 1'b0; e_wd[i] = 1'b0; e_rd[i] = 1'b0;
         e_rdata[i] = '0; e_addr[i] = '0; e_cause[i] = '0;
         e_baddr[i] = '0; e_bwdata[i] = '0; e_size[i] = '0;
      end
      for (int i = 0; i < 4096; i++) rmem[i] = 8'h00;
      lsu_bus.req_valid  = 1'b0;
      lsu_bus.req_store  = 1'b0;
      lsu_bus.req_funct3 = 3'b000;
      lsu_bus.req_base   = 32'h0;
      lsu_bus.req_imm    = 12'h0;
      lsu_bus.req_wdata  = 32'h0;
      drive_bus(1'b0, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      chk("rst_bus_addr", lsu_bus.bus_addr, 32'h0);
      chk("rst_bus_size", 32'(lsu_bus.bus_size), 32'h0);
      chk("rst_bus_wdata", lsu_bus.bus_wdata, 32'h0);
      rst = 1'b1;
      mem_clr = 1'b0;

      // SW then LW back-to-back
      s0 = n_strobe;
      do_req(1'b1, 3'b010, 32'h100, 12'h004, 32'hDEAD_BEEF, 0, 1'b0, -1, a);
      chk("sw_strobe_count", 32'(n_strobe - s0), 32'd1);
      chk("sw_strobe_addr", last_saddr, 32'h104);
      chk("sw_strobe_size", 32'(last_ssize), 32'd2);
      chk("sw_resp_latency", 32'(last_rv_cyc - a), 32'd1);
      do_req(1'b0, 3'b010, 32'h104, 12'h000, 32'h0, 0, 1'b0, -1, a2);
      chk("lw_rdata_lit", last_rdata, 32'hDEAD_BEEF);
      chk("lw_cause_lit", 32'(last_cause), 32'd0);
      chk("lw_resp_latency", 32'(last_rv_cyc - a2), 32'd1);
      chk("b2b_spacing", 32'(a2 - a), 32'd3);

      // Byte / half stores and sign vs zero extension
      do_req(1'b1, 3'b010, 32'h200, 12'h000, 32'h1234_5678, 0, 1'b0, -1, a);
      do_req(1'b1, 3'b000, 32'h200, 12'h000, 32'h0000_00F0, 0, 1'b0, -1, a);
      do_req(1'b0, 3'b000, 32'h200, 12'h000, 32'h0, 0, 1'b0, -1, a);
      chk("lb_rdata_lit", last_rdata, 32'hFFFF_FFF0);
      do_req(1'b0, 3'b100, 32'h200, 12'h000, 32'h0, 0, 1'b0, -1, a);
      chk("lbu_rdata_lit", last_rdata, 32'h0000_00F0);
      do_req(1'b1, 3'b001, 32'h202, 12'h000, 32'h0000_8001, 0, 1'b0, -1, a);
      do_req(1'b0, 3'b001, 32'h202, 12'h000, 32'h0, 0, 1'b0, -1, a);
      chk("lh_rdata_lit", last_rdata, 32'hFFFF_8001);
      do_req(1'b0, 3'b101, 32'h202, 12'h000, 32'h0, 0, 1'b0, -1, a);
      do_req(1'b0, 3'b010, 32'h108, 12'hFFC, 32'h0, 0, 1'b0, -1, a);
      chk("neg_imm_lw_lit", last_rdata, 32'hDEAD_BEEF);

      // Misaligned and illegal: no strobe, response in the next cycle
      s0 = n_strobe;
      do_req(1'b0, 3'b010, 32'h100, 12'h002, 32'h0, 0, 1'b0, -1, a);
      chk("mis_lw_cause", 32'(last_cause), 32'd1);
      chk("mis_lw_addr", last_addr, 32'h102);
      chk("mis_lw_latency", 32'(last_rv_cyc - a), 32'd0);
      do_req(1'b0, 3'b001, 32'h100, 12'h003, 32'h0, 0, 1'b0, -1, a);
      chk("mis_lh_addr", last_addr, 32'h103);
      do_req(1'b0, 3'b011, 32'h100, 12'h000, 32'h0, 0, 1'b0, -1, a);
      chk("ill_load_cause", 32'(last_cause), 32'd2);
      do_req(1'b1, 3'b100, 32'h100, 12'h000, 32'h1, 0, 1'b0, -1, a);
      do_req(1'b1, 3'b110, 32'h101, 12'h000, 32'h1, 0, 1'b0, -1, a);
      chk("ill_over_mis_cause", 32'(last_cause), 32'd2);
      chk("exc_strobe_count", 32'(n_strobe - s0), 32'd0);

      // Timeout, late ready, busy stall
      s0 = n_strobe;
      do_req(1'b0, 3'b010, 32'h104, 12'h000, 32'h0, 16, 1'b0, -1, a);
      chk("timeout_cause", 32'(last_cause), 32'd3);
      chk("timeout_latency", 32'(last_rv_cyc - a), 32'd16);
      chk("timeout_strobe_count", 32'(n_strobe - s0), 32'd0);
      do_req(1'b0, 3'b010, 32'h104, 12'h000, 32'h0, 3, 1'b0, -1, a);
      chk("late_lw_latency", 32'(last_rv_cyc - a), 32'd4);
      do_req(1'b1, 3'b010, 32'h108, 12'h000, 32'h0BAD_F00D, 2, 1'b1, -1, a);
      do_req(1'b0, 3'b010, 32'h108, 12'h000, 32'h0, 1, 1'b1, -1, a);
      chk("busy_lw_rdata_lit", last_rdata, 32'h0BAD_F00D);

      // Reset while a store waits in ACCESS: discarded, no response
      s0 = n_strobe;
      r0 = n_resp;
      do_req(1'b1, 3'b010, 32'h300, 12'h000, 32'hCAFE_F00D, 5, 1'b0, 1, a);
      chk("rst_no_resp", 32'(n_resp - r0), 32'd0);
      chk("rst_no_strobe", 32'(n_strobe - s0), 32'd0);
      chk("rst_mid_bus_addr", lsu_bus.bus_addr, 32'h0);
      do_req(1'b0, 3'b010, 32'h300, 12'h000, 32'h0, 0, 1'b0, -1, a);
      chk("rst_store_dropped", last_rdata, 32'h0);

      // Effective address wrap-around
      do_req(1'b0, 3'b000, 32'hFFFF_FFFF, 12'h001, 32'h0, 0, 1'b0, -1, a);
      chk("wrap_bus_addr", last_saddr, 32'h0);
      chk("wrap_resp_addr", last_addr, 32'h0);

      repeat (2) @(posedge clk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
